mem_stage_lsu: RTL and testbench
================================

# mem_stage_lsu

Load/store unit for the MEM stage of the 64-bit pipelined CPU. Takes the memory operation held in the EX/MEM register, runs a req/ack transaction on the data-memory port, aligns and zero-extends load data, and presents `mem_read_data` to the MEM/WB register. While a transaction is pending, it stalls the pipeline, with a watchdog that bounds the stall.

## Interface
Parameters:
- `TIMEOUT`, 16: maximum BUSY cycles without `dmem_ack` before the access is abandoned (≥ 2).

Ports:
- `clk`  in  1  pipeline clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ex_mem_valid`  in  1  EX/MEM register holds a live instruction.
- `ex_mem_M`  in  `struct_M`  memory controls: `mem_read`, `mem_write`, `byte_op` (1 = LDURB/STURB, 0 = doubleword).
- `ex_mem_address`  in  64  effective address (ALU result).
- `ex_mem_write_data`  in  64  store data (Rt value).
- `dmem_req`  out  1  request to data memory; registered.
- `dmem_we`  out  1  1 = write; registered.
- `dmem_addr`  out  64  `{ex_mem_address[63:3], 3'b000}`; registered.
- `dmem_wdata`  out  64  store data; registered.
- `dmem_be`  out  8  byte enables; registered.
- `dmem_ack`  in  1  memory completion; sampled only in BUSY.
- `dmem_rdata`  in  64  read data; valid in the cycle `dmem_ack`=1.
- `mem_read_data`  out  64  load result to MEM/WB.
- `mem_stall`  out  1  hold PC, IF/ID, ID/EX and EX/MEM; bubble into MEM/WB.
- `mem_misaligned`  out  1  one-cycle pulse: doubleword access with `address[2:0]≠0`.
- `mem_bus_error`  out  1  one-cycle pulse: watchdog expired.

## Operation
- FSM states: IDLE, BUSY, DONE.
- **IDLE, no memory op.** The condition is `ex_mem_valid`=0 or neither `mem_read` nor `mem_write` set. `mem_stall`=0 and `mem_read_data`=0. The state stays IDLE.
- **IDLE, misaligned doubleword op.** `mem_misaligned`=1 for this cycle only. No request, no stall, `mem_read_data`=0. The state stays IDLE.
- **IDLE, aligned op.** `mem_stall`=1 combinationally. On the clock edge:
  - `dmem_*` are latched.
  - `dmem_req`←1.
  - The watchdog counter ←0.
  - The state →BUSY.
- `mem_read` and `mem_write` both set: treated as a read.
- **Byte store.** `dmem_be = 8'b1 << address[2:0]`. `dmem_wdata` carries the low byte of the store data replicated into all 8 lanes.
- **Doubleword store.** `dmem_be = 8'hFF`.
- **Reads.** `dmem_we`=0 and `dmem_be = 8'hFF`.
- **BUSY.** `mem_stall`=1 and `dmem_req` is held with all `dmem_*` stable. The counter increments each cycle.
  - If `dmem_ack`=1: `dmem_req`←0, the load result is captured into the data register, and the state →DONE.
  - Else if the counter reaches `TIMEOUT-1`: `dmem_req`←0, the data register ←0, `mem_bus_error` pulses in the following cycle, and the state →DONE.
- **Load result.**
  - Byte load: `{56'b0, dmem_rdata[8*address[2:0] +: 8]}`.
  - Doubleword load: `dmem_rdata`.
  - Store: 0.
- **DONE.** `mem_stall`=0 and `mem_read_data` = the captured register. MEM/WB samples at the end of this cycle and the pipeline advances. The state →IDLE unconditionally, so the same op is never re-issued.
- **Outside BUSY.** `dmem_ack` is ignored.
- **Counter width.** `$clog2(TIMEOUT)`; it saturates and never wraps.

## Timing
- **Minimum latency.** The op appears in cycle 0 with ack in cycle 1 (the first BUSY cycle). The result is on `mem_read_data` in cycle 2. `mem_stall` is high in cycles 0–1, giving 2 stall cycles.
- **Ack after k BUSY cycles.** Stall lasts k+1 cycles.
- **Timeout.** Stall lasts `TIMEOUT`+1 cycles. `mem_bus_error` is high in the DONE cycle.
- **Non-memory and misaligned ops.** Zero stall; outputs are combinational from the EX/MEM inputs.
- **Reset values.** All outputs are 0 and the state is IDLE. Reset is asynchronous, so `dmem_req` drops immediately even in mid-BUSY. A late ack after reset is ignored.

## Structure
- Package `structures` (shared with `struct_WB`) gains:
  - `struct_M {logic mem_read; logic mem_write; logic byte_op;}`
  - enum `lsu_state_t {LSU_IDLE, LSU_BUSY, LSU_DONE}`.
- One natural sub-module: `lsu_load_align`. It is combinational: byte select and zero-extension from `dmem_rdata`, `address[2:0]` and `byte_op`. It is reused by any future halfword/word support.
- The watchdog counter and the FSM live in `mem_stage_lsu`.

## Test plan
- **Doubleword load, fast ack.** LDUR at address 0x100 with ack in the first BUSY cycle, `dmem_rdata=64'hDEAD_BEEF_0123_4567`. Required: `dmem_addr`=0x100 and `dmem_be`=FF. `mem_read_data` equals the rdata value in cycle 2, and `mem_stall` is high exactly 2 cycles.
- **Byte load, delayed ack.** LDURB at 0x10B, rdata 0x8877665544332211, ack after 3 BUSY cycles. Required: `dmem_addr`=0x108 and `mem_read_data`=0x44. `mem_stall` is high 4 cycles.
- **Byte store.** STURB at 0x205 with data 0x…AB. Required: `dmem_we`=1, `dmem_be`=8'b0010_0000, `dmem_wdata`=0xABABABABABABABAB. `mem_read_data`=0 in DONE.
- **Misaligned doubleword.** LDUR at 0x104. Required: `mem_misaligned` high 1 cycle, no `dmem_req`, `mem_stall`=0.
- **Watchdog expiry.** `TIMEOUT`=4 with ack never asserted. Required: `dmem_req` high 4 cycles, then `mem_bus_error` high 1 cycle with `mem_read_data`=0. The FSM is in IDLE on the next cycle.
- **Reset mid-operation.** `rst` asserted low in the 2nd BUSY cycle, with ack pulsed 1 cycle after release. Required: `dmem_req` and `mem_stall` drop immediately, the late ack is ignored, and the state is IDLE.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline-register types for the MEM stage and the load/store unit.
// Also holds the byte-enable helper used when a request is issued.
package structures;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
    } struct_WB;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic byte_op;
    } struct_M;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_BUSY,
        LSU_DONE
    } lsu_state_t;

    localparam int XLEN       = 64;
    localparam int BYTE_LANES = XLEN / 8;

    // Only byte stores narrow the enables; every read fetches the whole doubleword.
    function automatic logic [BYTE_LANES-1:0] lsu_byte_en(
        input logic       byte_op,
        input logic       is_write,
        input logic [2:0] off
    );
        logic [BYTE_LANES-1:0] be;
        be = '1;
        if (byte_op && is_write) be = 8'b1 << off;
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/ack port between the load/store unit and the data memory.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [7:0]  dmem_be;
    logic        dmem_ack;
    logic [63:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_lsu_load_align.sv
// Combinational load alignment: picks the addressed byte lane and zero-extends,
// or passes the doubleword through.
module lsu_load_align #(
    parameter int NUM_LANES = 8,
    parameter int VEC_W     = 8,
    localparam int OW       = $clog2(NUM_LANES)
) (
    input  logic [NUM_LANES*VEC_W-1:0] rdata,
    input  logic [OW-1:0]              off,
    input  logic                       byte_op,
    output logic [NUM_LANES*VEC_W-1:0] data
);
    logic [NUM_LANES-1:0][VEC_W-1:0] lanes;
    logic [VEC_W-1:0]                sel;

    assign lanes = rdata;
    assign sel   = lanes[off];
    assign data  = byte_op ? {{(NUM_LANES-1)*VEC_W{1'b0}}, sel} : rdata;
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: issues one req/ack transaction per memory op,
// stalls the pipeline while it is outstanding, and bounds the wait with a watchdog.
module mem_stage_lsu
    import structures::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_mem_valid,
    input  struct_M          ex_mem_M,
    input  logic [63:0]      ex_mem_address,
    input  logic [63:0]      ex_mem_write_data,
    mem_stage_lsu_if.master  dmem,
    output logic [63:0]      mem_read_data,
    output logic             mem_stall,
    output logic             mem_misaligned,
    output logic             mem_bus_error
);
    localparam int            CW       = $clog2(TIMEOUT);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    lsu_state_t    state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          is_mem, misaligned, is_write;
    logic          issue, ack_hit, expire;
    logic          lat_read, lat_byte;
    logic [2:0]    lat_off;
    logic [63:0]   data_q, aligned;
    logic          bus_err_q;

    assign is_mem     = ex_mem_valid & (ex_mem_M.mem_read | ex_mem_M.mem_write);
    assign misaligned = is_mem & ~ex_mem_M.byte_op & (|ex_mem_address[2:0]);
    // read+write together is resolved as a read
    assign is_write   = ex_mem_M.mem_write & ~ex_mem_M.mem_read;

    always_comb begin
        state_d        = state_q;
        issue          = 1'b0;
        ack_hit        = 1'b0;
        expire         = 1'b0;
        mem_stall      = 1'b0;
        mem_misaligned = 1'b0;
        mem_read_data  = '0;
        case (state_q)
            LSU_IDLE: begin
                mem_misaligned = misaligned;
                if (is_mem && !misaligned) begin
                    issue     = 1'b1;
                    mem_stall = 1'b1;
                    state_d   = LSU_BUSY;
                end
            end
            LSU_BUSY: begin
                mem_stall = 1'b1;
                if (dmem.dmem_ack) begin
                    ack_hit = 1'b1;
                    state_d = LSU_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    expire  = 1'b1;
                    state_d = LSU_DONE;
                end
            end
            LSU_DONE: begin
                mem_read_data = data_q;
                state_d       = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
        // combinational outputs are forced quiet while reset is held
        if (!rst) begin
            mem_stall      = 1'b0;
            mem_misaligned = 1'b0;
            issue          = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= LSU_IDLE;
        else      state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= '0;
            dmem.dmem_wdata <= '0;
            dmem.dmem_be    <= '0;
            cnt_q           <= '0;
            lat_read        <= 1'b0;
            lat_byte        <= 1'b0;
            lat_off         <= '0;
        end else if (issue) begin
            dmem.dmem_req   <= 1'b1;
            dmem.dmem_we    <= is_write;
            dmem.dmem_addr  <= {ex_mem_address[63:3], 3'b000};
            dmem.dmem_be    <= lsu_byte_en(ex_mem_M.byte_op, is_write, ex_mem_address[2:0]);
            dmem.dmem_wdata <= !is_write        ? 64'd0 :
                               ex_mem_M.byte_op ? {8{ex_mem_write_data[7:0]}} :
                                                  ex_mem_write_data;
            cnt_q           <= '0;
            lat_read        <= ex_mem_M.mem_read;
            lat_byte        <= ex_mem_M.byte_op;
            lat_off         <= ex_mem_address[2:0];
        end else if (state_q == LSU_BUSY) begin
            if (ack_hit || expire) dmem.dmem_req <= 1'b0;
            if (cnt_q != CNT_LAST) cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q    <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= expire;
            if (ack_hit)     data_q <= lat_read ? aligned : 64'd0;
            else if (expire) data_q <= '0;
        end
    end

    assign mem_bus_error = bus_err_q;

    lsu_load_align u_align (
        .rdata   (dmem.dmem_rdata),
        .off     (lat_off),
        .byte_op (lat_byte),
        .data    (aligned)
    );
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a short watchdog (TIMEOUT=4).
module tb_mem_stage_lsu;
    import structures::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_mem_valid;
    struct_M     ex_mem_M;
    logic [63:0] ex_mem_address;
    logic [63:0] ex_mem_write_data;
    logic [63:0] mem_read_data;
    logic        mem_stall, mem_misaligned, mem_bus_error;

    int total = 0;
    int bad   = 0;
    int stall_n, req_n;

    mem_stage_lsu_if bus ();

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_M          (ex_mem_M),
        .ex_mem_address    (ex_mem_address),
        .ex_mem_write_data (ex_mem_write_data),
        .dmem              (bus),
        .mem_read_data     (mem_read_data),
        .mem_stall         (mem_stall),
        .mem_misaligned    (mem_misaligned),
        .mem_bus_error     (mem_bus_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic op(input logic v, input logic rd, input logic wr, input logic bt,
                      input logic [63:0] a, input logic [63:0] wd);
        ex_mem_valid       = v;
        ex_mem_M.mem_read  = rd;
        ex_mem_M.mem_write = wr;
        ex_mem_M.byte_op   = bt;
        ex_mem_address     = a;
        ex_mem_write_data  = wd;
    endtask

    task automatic nxt();
        stall_n += int'(mem_stall);
        req_n   += int'(bus.dmem_req);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        op(0, 0, 0, 0, 64'd0, 64'd0);
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 64'd0;
        #2;
        chk("rst_req",   bus.dmem_req,   1'b0);
        chk("rst_stall", mem_stall,      1'b0);
        chk("rst_rdata", mem_read_data,  64'd0);
        chk("rst_berr",  mem_bus_error,  1'b0);
        chk("rst_state", dut.state_q,    LSU_IDLE);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // doubleword load, ack in first BUSY cycle
        stall_n = 0;
        op(1, 1, 0, 0, 64'h100, 64'd0);
        #2; chk("t1_stall_c0", mem_stall, 1'b1);
        nxt();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hDEAD_BEEF_0123_4567;
        #2;
        chk("t1_req",  bus.dmem_req,  1'b1);
        chk("t1_addr", bus.dmem_addr, 64'h100);
        chk("t1_be",   bus.dmem_be,   8'hFF);
        chk("t1_we",   bus.dmem_we,   1'b0);
        nxt();
        bus.dmem_ack = 1'b0;
        #2;
        chk("t1_data",  mem_read_data, 64'hDEAD_BEEF_0123_4567);
        chk("t1_stall", mem_stall,     1'b0);
        chk("t1_req_d", bus.dmem_req,  1'b0);
        nxt();
        op(0, 0, 0, 0, 64'd0, 64'd0);
        chk("t1_stall_n", 64'(stall_n), 64'd2);

        // byte load, ack on third BUSY cycle
        stall_n = 0;
        op(1, 1, 0, 1, 64'h10B, 64'd0);
        #2; nxt();
        #2; chk("t2_addr", bus.dmem_addr, 64'h108);
        nxt();
        #2; nxt();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'h8877_6655_4433_2211;
        #2; nxt();
        bus.dmem_ack = 1'b0;
        #2; chk("t2_data", mem_read_data, 64'h44);
        nxt();
        op(0, 0, 0, 0, 64'd0, 64'd0);
        chk("t2_stall_n", 64'(stall_n), 64'd4);

        // byte store
        op(1, 0, 1, 1, 64'h205, 64'h1234_5678_9ABC_DEAB);
        #2; nxt();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #2;
        chk("t3_we",    bus.dmem_we,    1'b1);
        chk("t3_be",    bus.dmem_be,    8'b0010_0000);
        chk("t3_wdata", bus.dmem_wdata, 64'hABAB_ABAB_ABAB_ABAB);
        chk("t3_addr",  bus.dmem_addr,  64'h200);
        nxt();
        bus.dmem_ack = 1'b0;
        #2; chk("t3_data", mem_read_data, 64'd0);
        nxt();
        op(0, 0, 0, 0, 64'd0, 64'd0);

        // doubleword store
        op(1, 0, 1, 0, 64'h300, 64'h1122_3344_5566_7788);
        #2; nxt();
        bus.dmem_ack = 1'b1;
        #2;
        chk("t3b_be",    bus.dmem_be,    8'hFF);
        chk("t3b_wdata", bus.dmem_wdata, 64'h1122_3344_5566_7788);
        chk("t3b_we",    bus.dmem_we,    1'b1);
        nxt();
        bus.dmem_ack = 1'b0;
        #2; chk("t3b_data", mem_read_data, 64'd0);
        nxt();
        op(0, 0, 0, 0, 64'd0, 64'd0);

        // misaligned doubleword
        op(1, 1, 0, 0, 64'h104, 64'd0);
        #2;
        chk("t4_mis",   mem_misaligned, 1'b1);
        chk("t4_stall", mem_stall,      1'b0);
        chk("t4_data",  mem_read_data,  64'd0);
        nxt();
        op(0, 1, 0, 0, 64'h104, 64'd0);
        #2;
        chk("t4_mis_off", mem_misaligned, 1'b0);
        chk("t4_noreq",   bus.dmem_req,   1'b0);
        chk("t4_state",   dut.state_q,    LSU_IDLE);
        nxt();

        // live instruction without a memory op
        op(1, 0, 0, 0, 64'h108, 64'd0);
        #2;
        chk("nm_stall", mem_stall,     1'b0);
        chk("nm_data",  mem_read_data, 64'd0);
        nxt();
        op(0, 0, 0, 0, 64'd0, 64'd0);

        // watchdog expiry with TIMEOUT=4
        stall_n = 0; req_n = 0;
        bus.dmem_rdata = 64'h5555_5555_5555_5555;
        op(1, 1, 0, 0, 64'h400, 64'd0);
        #2; nxt();
        repeat (4) begin #2; nxt(); end
        #2;
        chk("t5_berr",  mem_bus_error, 1'b1);
        chk("t5_data",  mem_read_data, 64'd0);
        chk("t5_req",   bus.dmem_req,  1'b0);
        chk("t5_stall", mem_stall,     1'b0);
        nxt();
        op(0, 0, 0, 0, 64'd0, 64'd0);
        #2;
        chk("t5_state",   dut.state_q,   LSU_IDLE);
        chk("t5_berr_lo", mem_bus_error, 1'b0);
        chk("t5_req_n",   64'(req_n),    64'd4);
        chk("t5_stall_n", 64'(stall_n),  64'd5);
        nxt();

        // asynchronous reset in the second BUSY cycle, late ack afterwards
        op(1, 1, 0, 0, 64'h600, 64'd0);
        #2; nxt();
        #2; nxt();
        #2; chk("t6_req_busy", bus.dmem_req, 1'b1);
        rst = 1'b0;
        #1;
        chk("t6_req_rst",   bus.dmem_req, 1'b0);
        chk("t6_stall_rst", mem_stall,    1'b0);
        chk("t6_state_rst", dut.state_q,  LSU_IDLE);
        @(posedge clk); #1;
        op(0, 0, 0, 0, 64'd0, 64'd0);
        rst = 1'b1;
        #2; nxt();
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 64'hCAFE_F00D_CAFE_F00D;
        #2;
        chk("t6_req_ack",   bus.dmem_req, 1'b0);
        chk("t6_stall_ack", mem_stall,    1'b0);
        nxt();
        bus.dmem_ack = 1'b0;
        #2;
        chk("t6_state", dut.state_q,   LSU_IDLE);
        chk("t6_data",  mem_read_data, 64'd0);
        chk("t6_berr",  mem_bus_error, 1'b0);
        nxt();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
